// File: rtl/dram_device.sv
// dram_device: single-bank command-level DRAM responder with CAS-latency read pipeline.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   CSn, RASn, CASn     active-low command strobes (commands ignored while CSn=1)
//   WEn[3:0]            active-low per-byte write enables (bit i gates D[8i+7:8i])
//   A[10:0], D[31:0]    row/column address and write data
//   Q[31:0], VALID      read data and its one-cycle valid strobe, CAS_LAT cycles after READ
//   row_open, err       a row is active; sticky protocol-violation flag
module dram_device #(
   parameter int ROW_BITS = 11,
   parameter int COL_BITS = 10,
   parameter int CAS_LAT  = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CSn,
   input  logic        RASn,
   input  logic        CASn,
   input  logic [3:0]  WEn,
   input  logic [10:0] A,
   input  logic [31:0] D,
   output logic [31:0] Q,
   output logic        VALID,
   output logic        row_open,
   output logic        err
);
   logic [31:0] mem [0:(1 << (ROW_BITS + COL_BITS)) - 1];
   logic [ROW_BITS-1:0] open_row;
   logic [CAS_LAT-1:0] pv;
   logic [31:0] pd [CAS_LAT];
   logic ras_cmd, cas_cmd, act, pre, rd, wr, bad;
   logic [ROW_BITS+COL_BITS-1:0] addr;

   always_comb begin
      ras_cmd = !CSn && !RASn && CASn;
      cas_cmd = !CSn && RASn && !CASn;
      act     = ras_cmd && (WEn == 4'hF) && !row_open;
      pre     = ras_cmd && (WEn == 4'h0);
      rd      = cas_cmd && (WEn == 4'hF) && row_open;
      wr      = cas_cmd && (WEn != 4'hF) && row_open;
      bad     = (!CSn && !RASn && !CASn) ||
                (ras_cmd && (WEn != 4'hF) && (WEn != 4'h0)) ||
                (ras_cmd && (WEn == 4'hF) && row_open) ||
                (cas_cmd && !row_open);
      addr    = {open_row, A[COL_BITS-1:0]};
   end

   // Data stages only advance behind a valid bit, so the last stage keeps the
   // most recently returned word and doubles as the holding register for Q.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         row_open <= 1'b0;
         open_row <= '0;
         err      <= 1'b0;
         pv       <= '0;
         for (int i = 0; i < CAS_LAT; i++) pd[i] <= '0;
      end else begin
         if (act) begin
            row_open <= 1'b1;
            open_row <= A[ROW_BITS-1:0];
         end else if (pre) row_open <= 1'b0;
         err   <= err | bad;
         pv[0] <= rd;
         if (rd) pd[0] <= mem[addr];
         for (int i = 1; i < CAS_LAT; i++) begin
            pv[i] <= pv[i-1];
            if (pv[i-1]) pd[i] <= pd[i-1];
         end
      end

   always_ff @(posedge clk)
      if (wr)
         for (int i = 0; i < 4; i++)
            if (!WEn[i]) mem[addr][8*i +: 8] <= D[8*i +: 8];

   assign VALID = pv[CAS_LAT-1];
   assign Q     = pd[CAS_LAT-1];
endmodule

// File: tb/tb_dram_device.sv
// tb_dram_device: directed self-checking bench for dram_device.
module tb_dram_device;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1;
   logic [3:0]  WEn = 4'hF;
   logic [10:0] A = '0;
   logic [31:0] D = '0;
   logic [31:0] Q;
   logic        VALID, row_open, err;
   int checks = 0;
   int failures = 0;

   dram_device dut (
      .clk(clk), .rst(rst), .CSn(CSn), .RASn(RASn), .CASn(CASn),
      .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID),
      .row_open(row_open), .err(err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic csn, input logic rasn, input logic casn,
                        input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
   endtask

   task automatic nop();                 drive(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0); endtask
   task automatic act(input logic [10:0] a); drive(1'b0, 1'b0, 1'b1, 4'hF, a, 32'h0); endtask
   task automatic pre();                 drive(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0); endtask
   task automatic rd(input logic [10:0] a);  drive(1'b0, 1'b1, 1'b0, 4'hF, a, 32'h0); endtask
   task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] wen);
      drive(1'b0, 1'b1, 1'b0, wen, a, d);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (Q !== 32'h0) begin failures++; $display("FAIL reset_q: got %h expected %h", Q, 32'h0); end
      checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", VALID); end
      checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL reset_row_open: got %b expected 0", row_open); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      act(11'h012);
      wr(11'h034, 32'hDEADBEEF, 4'h0);
      checks++; if (row_open !== 1'b1) begin failures++; $display("FAIL basic_row_open: got %b expected 1", row_open); end
      rd(11'h034);
      for (int k = 1; k <= 6; k++) begin
         nop();
         checks++; if (VALID !== (k == 5)) begin failures++; $display("FAIL basic_valid k=%0d: got %b expected %b", k, VALID, k == 5); end
         if (k == 5) begin
            checks++; if (Q !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_q: got %h expected %h", Q, 32'hDEADBEEF); end
         end
      end
      pre();
      nop();
      checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL basic_row_closed: got %b expected 0", row_open); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b expected 0", err); end
   endtask

   task automatic test_byte_mask();
      act(11'h001);
      wr(11'h007, 32'h11223344, 4'h0);
      wr(11'h007, 32'hAABBCCDD, 4'b1010);
      rd(11'h007);
      repeat (5) nop();
      checks++; if (VALID !== 1'b1) begin failures++; $display("FAIL mask_valid: got %b expected 1", VALID); end
      checks++; if (Q !== 32'h11BB33DD) begin failures++; $display("FAIL mask_q: got %h expected %h", Q, 32'h11BB33DD); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) wr(11'(i), 32'hA0 + 32'(i), 4'h0);
      for (int i = 0; i < 4; i++) rd(11'(i));
      for (int k = 1; k <= 6; k++) begin
         nop();
         checks++; if (VALID !== (k >= 2 && k <= 5)) begin failures++; $display("FAIL b2b_valid k=%0d: got %b expected %b", k, VALID, k >= 2 && k <= 5); end
         if (k >= 2 && k <= 5) begin
            checks++; if (Q !== 32'hA0 + 32'(k - 2)) begin failures++; $display("FAIL b2b_q k=%0d: got %h expected %h", k, Q, 32'hA0 + 32'(k - 2)); end
         end
      end
   endtask

   task automatic test_hazard();
      wr(11'h005, 32'h5, 4'h0);
      rd(11'h005);
      wr(11'h005, 32'h77, 4'h0);
      pre();
      for (int k = 1; k <= 3; k++) begin
         nop();
         checks++; if (VALID !== (k == 3)) begin failures++; $display("FAIL hazard_valid k=%0d: got %b expected %b", k, VALID, k == 3); end
      end
      checks++; if (Q !== 32'h5) begin failures++; $display("FAIL hazard_old_q: got %h expected %h", Q, 32'h5); end
      checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL hazard_row_closed: got %b expected 0", row_open); end
      act(11'h001);
      rd(11'h005);
      repeat (5) nop();
      checks++; if (VALID !== 1'b1) begin failures++; $display("FAIL hazard_new_valid: got %b expected 1", VALID); end
      checks++; if (Q !== 32'h77) begin failures++; $display("FAIL hazard_new_q: got %h expected %h", Q, 32'h77); end
   endtask

   task automatic test_errors();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", err); end
      rd(11'h009);
      nop();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_read_closed: got %b expected 1", err); end
      checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL err_row_still_closed: got %b expected 0", row_open); end
      act(11'h002);
      wr(11'h009, 32'h12345678, 4'h0);
      act(11'h003);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h009, 32'hFFFFFFFF);
      drive(1'b0, 1'b0, 1'b1, 4'h5, 11'h000, 32'h0);
      nop();
      checks++; if (row_open !== 1'b1) begin failures++; $display("FAIL err_row_kept: got %b expected 1", row_open); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
      rd(11'h009);
      repeat (5) nop();
      checks++; if (VALID !== 1'b1) begin failures++; $display("FAIL err_read_valid: got %b expected 1", VALID); end
      checks++; if (Q !== 32'h12345678) begin failures++; $display("FAIL err_data_kept: got %h expected %h", Q, 32'h12345678); end
      pre();
      wr(11'h009, 32'h0, 4'h0);
      act(11'h002);
      rd(11'h009);
      repeat (5) nop();
      checks++; if (Q !== 32'h12345678) begin failures++; $display("FAIL err_closed_write: got %h expected %h", Q, 32'h12345678); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_still_set: got %b expected 1", err); end
   endtask

   task automatic test_reset_midflight();
      wr(11'h00A, 32'hCAFEF00D, 4'h0);
      rd(11'h00A);
      nop();
      nop();
      #2 rst = 1'b0;
      #1;
      checks++; if (Q !== 32'h0) begin failures++; $display("FAIL mid_q: got %h expected %h", Q, 32'h0); end
      checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", VALID); end
      checks++; if (row_open !== 1'b0) begin failures++; $display("FAIL mid_row_open: got %b expected 0", row_open); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err: got %b expected 0", err); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         nop();
         checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL mid_no_valid k=%0d: got %b expected 0", k, VALID); end
      end
      checks++; if (Q !== 32'h0) begin failures++; $display("FAIL mid_q_after: got %h expected %h", Q, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_mask();
      test_back_to_back();
      test_hazard();
      test_errors();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dram_device.md
# dram_device

Command-level DRAM responder sitting on the far side of the DRAM pin interface that the AXI DRAM wrapper drives. It decodes CSn/RASn/CASn/WEn strobes into activate, read, write and precharge commands against a single-bank row/column array. Read data returns on Q with a fixed CAS latency and a one-cycle VALID pulse. It serves as the memory device in system simulation and as a synthesizable FPGA stand-in, and flags protocol violations for verification.

## Interface
- ROW_BITS, 11: row address width, taken from A[ROW_BITS-1:0] on ACT; must be ≤11.
- COL_BITS, 10: column address width, taken from A[COL_BITS-1:0] on READ/WRITE; must be ≤11.
- CAS_LAT, 5: cycles from the READ command edge to VALID; must be ≥1.

Reset rst is asynchronous, active-low; the clock is clk.
- clk  in  1  clock; all sampling on the rising edge
- rst  in  1  asynchronous, active-low reset
- CSn  in  1  chip select; commands are ignored while high
- RASn  in  1  row strobe, active low
- CASn  in  1  column strobe, active low
- WEn  in  4  per-byte write enable, active low; bit i gates D[8i+7:8i]
- A  in  11  row or column address
- D  in  32  write data
- Q  out  32  read data
- VALID  out  1  Q is valid this cycle
- row_open  out  1  a row is currently active
- err  out  1  sticky protocol-violation flag

## Operation
- The array holds 2^(ROW_BITS+COL_BITS) words of 32 bits each. The array is not reset.
- Commands are decoded on the clock edge when CSn=0:
  - ACT: RASn=0, CASn=1, WEn=4'hF. Latch open_row ← A[ROW_BITS-1:0] and set row_open=1.
  - PRE: RASn=0, CASn=1, WEn=4'h0. Clear row_open.
  - READ: RASn=1, CASn=0, WEn=4'hF. Sample word mem[open_row][A[COL_BITS-1:0]] at the command edge and push it into the latency pipeline.
  - WRITE: RASn=1, CASn=0, WEn≠4'hF. For each i with WEn[i]=0, write byte D[8i+7:8i] to mem[open_row][col]. All other bytes are unchanged.
  - NOP: RASn=1, CASn=1, any WEn.
- Illegal cases set err=1. The command has no effect on the array or the row state. The illegal cases are:
  - RASn=0 and CASn=0.
  - RASn=0, CASn=1, with WEn not equal to 4'hF or 4'h0.
  - ACT while row_open=1.
  - READ or WRITE while row_open=0.
- PRE while row_open=0 is legal and has no effect.
- err stays set until reset.
- Address bits above ROW_BITS or COL_BITS are ignored.
- Latency pipeline:
  - CAS_LAT stages, each holding a valid bit and 32 bits of data.
  - A new READ may be issued every cycle, so up to CAS_LAT reads can be outstanding.
- Q takes the pipeline output when it is valid and holds its last value otherwise.

## Timing
- Reset values: Q=0, VALID=0, row_open=0, err=0, pipeline valid bits all 0.
- Reset asserted mid-operation discards all in-flight reads and closes the row. VALID never asserts for reads issued before reset.
- A READ sampled at edge N drives VALID=1 and Q=data for exactly the cycle following edge N+CAS_LAT−1, i.e. CAS_LAT cycles after the command cycle.
  - With CAS_LAT=5 and the wrapper's delay counter at 0 on the command cycle, VALID is seen at counter value 5.
- Read data is sampled at the command edge:
  - A WRITE to the same address on a later edge does not affect an outstanding read.
  - A WRITE on the same edge is impossible, since it would need a second command.
- PRE or ACT issued while reads are in flight does not cancel them; data still returns on schedule.
- row_open updates on the edge after ACT or PRE. A READ or WRITE is legal from the next cycle on, so there is no tRCD check.
- err asserts on the edge following the illegal command.
- VALID is not gated by CSn; returning reads complete even while CSn=1.

## Test plan
- Basic write then read:
  - Stimulus: reset; ACT row 0x012; WRITE col 0x034 with D=0xDEADBEEF, WEn=0; READ col 0x034; PRE.
  - Required: VALID exactly 5 cycles after the READ cycle with Q=0xDEADBEEF; row_open 1 then 0; err=0.
- Byte masking:
  - Stimulus: write 0x11223344; then write D=0xAABBCCDD with WEn=4'b1010; read back.
  - Required: Q=0x11BB33DD.
- Back-to-back reads:
  - Stimulus: columns 0..3 preloaded with 0xA0..0xA3; four READs on consecutive cycles.
  - Required: four consecutive VALID cycles carrying 0xA0, 0xA1, 0xA2, 0xA3.
- Read/write hazard with precharge:
  - Stimulus: READ col 5 (old 0x5), then WRITE col 5 = 0x77 next cycle, then PRE.
  - Required: returned Q=0x5; a later read after re-ACT returns 0x77.
- Protocol errors:
  - Stimulus: READ with no open row; ACT twice; RASn=CASn=0.
  - Required: err=1 after the first violation and stays 1; array contents and row_open unchanged by each illegal command.
- Reset mid-flight:
  - Stimulus: assert rst 2 cycles after a READ.
  - Required: Q=0, VALID=0 immediately; no VALID after release; row_open=0; err=0.
